// File: rtl/comparador_troco_if.sv
// comparador_troco_if
// Bundles the request/actuator signals between the coin accumulator,
// the comparator and the dispenser/coin-return actuators.
//   valorMoedas    : accumulated credit (W_VALOR bits)
//   valorProduto   : selected product code (W_SEL bits)
//   enable         : purchase request, rising edge only
//   ack            : actuator done
//   liberarProduto : release product
//   devolverMoedas : return coins (amount in valorTroco)
//   valorTroco     : amount to return (W_VALOR bits)
//   ocupado        : transaction in progress
//   erro           : invalid code or timeout, sticky until next request
// modport master drives the requests, modport slave is the comparator.
interface comparador_troco_if #(
   parameter int W_VALOR = 8,
   parameter int W_SEL   = 3
);
   logic [W_VALOR-1:0] valorMoedas;
   logic [W_SEL-1:0]   valorProduto;
   logic               enable;
   logic               ack;
   logic               liberarProduto;
   logic               devolverMoedas;
   logic [W_VALOR-1:0] valorTroco;
   logic               ocupado;
   logic               erro;

   modport master (
      output valorMoedas, valorProduto, enable, ack,
      input  liberarProduto, devolverMoedas, valorTroco, ocupado, erro
   );

   modport slave (
      input  valorMoedas, valorProduto, enable, ack,
      output liberarProduto, devolverMoedas, valorTroco, ocupado, erro
   );
endinterface

// File: rtl/comparador_troco.sv
// comparador_troco
// Compares the latched coin credit against a per-product price table and
// either releases the product with change or refunds the full credit.
// Actuator outputs are held until ack or until TIMEOUT cycles elapse.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : comparador_troco_if.slave (credit/code/enable/ack in,
//           liberarProduto/devolverMoedas/valorTroco/ocupado/erro out)
module comparador_troco #(
   parameter int W_VALOR    = 8,
   parameter int N_PRODUTOS = 6,
   parameter int W_SEL      = 3,
   parameter logic [N_PRODUTOS*W_VALOR-1:0] PRECOS =
      {W_VALOR'(8), W_VALOR'(7), W_VALOR'(6), W_VALOR'(5), W_VALOR'(4), W_VALOR'(2)},
   parameter int TIMEOUT    = 1000
) (
   input logic               clk,
   input logic               reset,
   comparador_troco_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {OCIOSO, AVALIA, LIBERA, DEVOLVE} estado_t;

   estado_t            state_q, state_d;
   logic               enable_q;
   logic [W_VALOR-1:0] cred_q, cred_d;
   logic [W_SEL-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               lib_q, lib_d;
   logic               dev_q, dev_d;
   logic [W_VALOR-1:0] troco_q, troco_d;
   logic               ocupado_q, ocupado_d;
   logic               erro_q, erro_d;

   logic               pedido;
   logic [W_VALOR-1:0] preco_sel;
   logic [W_VALOR-1:0] troco_calc;

   // Table lookup by scanning the valid codes, so an out-of-range code
   // never produces an out-of-range slice.
   function automatic logic [W_VALOR-1:0] preco_de(input logic [W_SEL-1:0] s);
      logic [W_VALOR-1:0] p;
      p = '0;
      for (int i = 1; i <= N_PRODUTOS; i++) begin
         if (s == W_SEL'(i)) p = PRECOS[(i-1)*W_VALOR +: W_VALOR];
      end
      return p;
   endfunction

   function automatic logic codigo_valido(input logic [W_SEL-1:0] s);
      return (s != '0) && (int'(s) <= N_PRODUTOS);
   endfunction

   // Only a fresh rising edge of enable is a request; enable_q resets to 1
   // so an enable held high through reset is not taken as one.
   assign pedido     = bus.enable & ~enable_q;
   assign preco_sel  = preco_de(sel_q);
   // Used only when cred_q >= preco_sel, so it never wraps.
   assign troco_calc = cred_q - preco_sel;

   always_comb begin
      state_d = state_q;
      cred_d  = cred_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      lib_d   = lib_q;
      dev_d   = dev_q;
      troco_d = troco_q;
      erro_d  = erro_q;

      case (state_q)
         OCIOSO: begin
            if (pedido) begin
               cred_d  = bus.valorMoedas;
               sel_d   = bus.valorProduto;
               erro_d  = 1'b0;
               state_d = AVALIA;
            end
         end
         AVALIA: begin
            cnt_d = '0;
            if (!codigo_valido(sel_q)) begin
               state_d = DEVOLVE;
               lib_d   = 1'b0;
               dev_d   = 1'b1;
               troco_d = cred_q;
               erro_d  = 1'b1;
            end else if (cred_q >= preco_sel) begin
               state_d = LIBERA;
               lib_d   = 1'b1;
               dev_d   = (troco_calc != '0);
               troco_d = troco_calc;
            end else begin
               state_d = DEVOLVE;
               lib_d   = 1'b0;
               dev_d   = 1'b1;
               troco_d = cred_q;
            end
         end
         LIBERA: begin
            // ack has priority over a coincident timeout
            if (bus.ack) begin
               state_d = OCIOSO;
               lib_d   = 1'b0;
               dev_d   = 1'b0;
               troco_d = '0;
            end else if (cnt_q == CNT_FIM) begin
               // product never taken: fall back to a full refund
               state_d = DEVOLVE;
               lib_d   = 1'b0;
               dev_d   = 1'b1;
               troco_d = cred_q;
               erro_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DEVOLVE: begin
            if (bus.ack) begin
               state_d = OCIOSO;
               lib_d   = 1'b0;
               dev_d   = 1'b0;
               troco_d = '0;
            end else if (cnt_q == CNT_FIM) begin
               state_d = OCIOSO;
               lib_d   = 1'b0;
               dev_d   = 1'b0;
               troco_d = '0;
               erro_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = OCIOSO;
            lib_d   = 1'b0;
            dev_d   = 1'b0;
            troco_d = '0;
         end
      endcase

      ocupado_d = (state_d != OCIOSO);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= OCIOSO;
         enable_q  <= 1'b1;
         cred_q    <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         lib_q     <= 1'b0;
         dev_q     <= 1'b0;
         troco_q   <= '0;
         ocupado_q <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         enable_q  <= bus.enable;
         cred_q    <= cred_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         lib_q     <= lib_d;
         dev_q     <= dev_d;
         troco_q   <= troco_d;
         ocupado_q <= ocupado_d;
         erro_q    <= erro_d;
      end
   end

   assign bus.liberarProduto = lib_q;
   assign bus.devolverMoedas = dev_q;
   assign bus.valorTroco     = troco_q;
   assign bus.ocupado        = ocupado_q;
   assign bus.erro           = erro_q;

endmodule

// File: tb/tb_comparador_troco.sv
// tb_comparador_troco
// Scoreboard bench for comparador_troco with default prices and TIMEOUT=16.
module tb_comparador_troco;

   localparam int TMO = 16;

   typedef struct {
      logic       lib;
      logic       dev;
      logic [7:0] troco;
      logic       erro;
   } esperado_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   esperado_t fila[$];

   comparador_troco_if #(.W_VALOR(8), .W_SEL(3)) bus ();

   comparador_troco #(
      .W_VALOR(8), .N_PRODUTOS(6), .W_SEL(3), .TIMEOUT(TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic verifica(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Independent reference prices: product p -> preco[p]
   function automatic esperado_t modelo(input int c, input int s);
      int preco[7] = '{0, 2, 4, 5, 6, 7, 8};
      esperado_t e;
      if (s == 0 || s > 6) begin
         e.lib = 1'b0; e.dev = 1'b1; e.troco = 8'(c); e.erro = 1'b1;
      end else if (c >= preco[s]) begin
         e.lib = 1'b1; e.dev = ((c - preco[s]) != 0); e.troco = 8'(c - preco[s]); e.erro = 1'b0;
      end else begin
         e.lib = 1'b0; e.dev = 1'b1; e.troco = 8'(c); e.erro = 1'b0;
      end
      return e;
   endfunction

   task automatic saidas_zero(input string tag, input int erro_exp);
      verifica({tag, ".lib"},     bus.liberarProduto, 0);
      verifica({tag, ".dev"},     bus.devolverMoedas, 0);
      verifica({tag, ".troco"},   bus.valorTroco, 0);
      verifica({tag, ".ocupado"}, bus.ocupado, 0);
      verifica({tag, ".erro"},    bus.erro, erro_exp);
   endtask

   // Issue a request, then wait (bounded) for the actuator outputs and
   // compare them against the scoreboard entry.
   task automatic requisita(input string tag, input int c, input int s);
      int lat;
      esperado_t e;
      @(negedge clk);
      bus.valorMoedas  = 8'(c);
      bus.valorProduto = 3'(s);
      bus.enable       = 1'b1;
      fila.push_back(modelo(c, s));
      lat = 0;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bus.enable       = 1'b0;
            bus.valorMoedas  = 8'hA5;
            bus.valorProduto = 3'd3;
            verifica({tag, ".avalia_ocupado"}, bus.ocupado, 1);
            verifica({tag, ".avalia_erro"}, bus.erro, 0);
         end
         if (bus.liberarProduto || bus.devolverMoedas) begin
            lat = n;
            break;
         end
      end
      verifica({tag, ".latencia"}, lat, 2);
      e = fila.pop_front();
      verifica({tag, ".lib"},     bus.liberarProduto, int'(e.lib));
      verifica({tag, ".dev"},     bus.devolverMoedas, int'(e.dev));
      verifica({tag, ".troco"},   bus.valorTroco, int'(e.troco));
      verifica({tag, ".erro"},    bus.erro, int'(e.erro));
      verifica({tag, ".ocupado"}, bus.ocupado, 1);
   endtask

   task automatic confirma(input string tag, input int erro_exp);
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
      saidas_zero(tag, erro_exp);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.valorMoedas  = '0;
      bus.valorProduto = '0;
      bus.enable       = 1'b1;
      bus.ack          = 1'b0;

      // enable held high across reset: not a request
      repeat (3) @(negedge clk);
      saidas_zero("reset", 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      saidas_zero("enable_alto", 0);
      bus.enable = 1'b0;
      @(negedge clk);

      // ack in OCIOSO is ignored
      bus.ack = 1'b1;
      repeat (2) @(negedge clk);
      bus.ack = 1'b0;
      verifica("ack_ocioso.ocupado", bus.ocupado, 0);

      // exact payment
      requisita("exato", 5, 3);
      confirma("exato_ack", 0);

      // change, plus an ignored second edge during LIBERA
      requisita("troco", 10, 6);
      bus.enable = 1'b1;
      @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      verifica("troco_2o_pedido.lib", bus.liberarProduto, 1);
      verifica("troco_2o_pedido.troco", bus.valorTroco, 2);
      confirma("troco_ack", 0);
      repeat (2) @(negedge clk);
      verifica("troco_2o_pedido.ocioso", bus.ocupado, 0);

      // insufficient credit
      requisita("insuf", 3, 2);
      confirma("insuf_ack", 0);

      // invalid codes, erro sticky in OCIOSO
      requisita("cod0", 4, 0);
      confirma("cod0_ack", 1);
      requisita("cod7", 4, 7);
      confirma("cod7_ack", 1);

      // maximum credit
      requisita("max", 255, 6);
      confirma("max_ack", 0);

      // timeout path
      requisita("tmo", 9, 1);
      repeat (TMO - 1) @(negedge clk);
      verifica("tmo.libera_fim", bus.liberarProduto, 1);
      @(negedge clk);
      verifica("tmo.dev.lib",   bus.liberarProduto, 0);
      verifica("tmo.dev.dev",   bus.devolverMoedas, 1);
      verifica("tmo.dev.troco", bus.valorTroco, 9);
      verifica("tmo.dev.erro",  bus.erro, 1);
      repeat (TMO - 1) @(negedge clk);
      verifica("tmo.devolve_fim", bus.devolverMoedas, 1);
      @(negedge clk);
      saidas_zero("tmo.fim", 1);

      // next request clears erro (checked in AVALIA inside requisita)
      // ack coincident with the timeout cycle
      requisita("ack_tmo", 5, 3);
      repeat (TMO - 1) @(negedge clk);
      confirma("ack_tmo_fim", 0);

      // reset mid-LIBERA
      requisita("rst_meio", 10, 6);
      reset = 1'b1;
      @(negedge clk);
      saidas_zero("rst_meio", 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      verifica("rst_meio.sem_reembolso", bus.devolverMoedas, 0);
      requisita("pos_rst", 7, 4);
      confirma("pos_rst_ack", 0);

      verifica("fila_vazia", fila.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/comparador_troco.md
# comparador_troco

Parametrised transaction comparator for the vending-machine datapath. It compares the accumulated coin credit against a per-product price table and then either releases the product with computed change or refunds the full credit. It holds its outputs until the dispenser acknowledges, or until a timeout expires. It sits between the coin accumulator and the dispenser/coin-return actuators, and adds a registered FSM, edge-triggered requests, change calculation and timeout recovery to the earlier exact-match comparator.

## Interface
- `W_VALOR`, default 8: width of credit, price and change values.
- `N_PRODUTOS`, default 6: number of valid product codes, 1..N_PRODUTOS.
- `W_SEL`, default 3: width of the product selection code.
- `PRECOS`, default {8,7,6,5,4,2}: packed price table, N_PRODUTOS×W_VALOR bits; product p uses slice [(p-1)*W_VALOR +: W_VALOR].
- `TIMEOUT`, default 1000: cycles to wait for `ack` in LIBERA or DEVOLVE; must be ≥1.

Ports:
- `clk` in, 1: single clock; all logic on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `valorMoedas` in, W_VALOR: accumulated credit.
- `valorProduto` in, W_SEL: selected product code.
- `enable` in, 1: purchase request; only a rising edge counts.
- `ack` in, 1: actuator done; sampled only in LIBERA/DEVOLVE.
- `liberarProduto` out, 1: release product.
- `devolverMoedas` out, 1: return coins; the amount is `valorTroco`.
- `valorTroco` out, W_VALOR: amount to return.
- `ocupado` out, 1: transaction in progress (state ≠ OCIOSO).
- `erro` out, 1: invalid code or timeout; sticky until the next accepted request.

## Operation
- All outputs are registered. On reset, every output is 0, the state is OCIOSO, the timeout counter is 0, the latched credit and selection are 0, and the `enable` edge register (`enable_q`) is 1.
- Because `enable_q` resets to 1, an `enable` held high through reset is not a request; it must go low and then high again.
- **Request detection:** a request is `enable & ~enable_q`. It is accepted only in OCIOSO. A rising edge in any other state is dropped, not queued.
- **OCIOSO:** on a request, latch `valorMoedas` and `valorProduto`, clear `erro`, and go to AVALIA.
- **AVALIA** (always exactly 1 cycle), using the latched code sel and credit C:
  - sel = 0 or sel > N_PRODUTOS: go to DEVOLVE with valorTroco = C and erro = 1.
  - C ≥ PRECOS[sel]: go to LIBERA with valorTroco = C − PRECOS[sel].
  - Otherwise: go to DEVOLVE with valorTroco = C.
- **LIBERA:**
  - liberarProduto = 1; devolverMoedas = (valorTroco ≠ 0).
  - On `ack`: go to OCIOSO.
  - After TIMEOUT cycles with no `ack`: go to DEVOLVE with valorTroco = C (full refund), erro = 1, counter cleared.
- **DEVOLVE:**
  - liberarProduto = 0; devolverMoedas = 1.
  - On `ack`: go to OCIOSO.
  - On timeout: go to OCIOSO with erro = 1.
- **Entering OCIOSO:** liberarProduto, devolverMoedas and valorTroco go to 0; `erro` keeps its value.
- **Arithmetic:** the subtraction is performed only when C ≥ price, so there is no underflow; the result is W_VALOR bits.
  - Exact payment gives valorTroco = 0 and devolverMoedas = 0 during LIBERA.
  - C = 2^W_VALOR − 1 is legal.
- **Timeout counter:** width clog2(TIMEOUT+1). Cleared on entry to LIBERA/DEVOLVE and incremented each cycle in those states; timeout fires when the count reaches TIMEOUT−1 without `ack`.
- **Simultaneous `ack` and timeout:** `ack` wins; the transaction completes normally.
- **Reset mid-transaction:** the transaction is abandoned with no refund; all outputs read 0 after the reset edge.
- `valorMoedas` and `valorProduto` changing after acceptance have no effect.

## Timing
- Edge k samples a request → after edge k: state AVALIA, ocupado = 1.
- After edge k+1: state LIBERA or DEVOLVE; liberarProduto, devolverMoedas, valorTroco and erro are valid. Request-to-actuator latency is 2 cycles.
- `ack` sampled high at edge j in LIBERA/DEVOLVE → after edge j: all actuator outputs 0, ocupado = 0.
- A new request can be accepted at edge j+1 at the earliest, provided `enable` showed a fresh rising edge.
- With no `ack`, LIBERA lasts exactly TIMEOUT cycles before the transition to DEVOLVE; DEVOLVE likewise lasts TIMEOUT cycles.
- `ack` high in OCIOSO or AVALIA is ignored.

## Test plan
All scenarios use default prices and TIMEOUT = 16.
- Exact payment: credit 5, code 3, `enable` edge.
  - Two cycles later: liberarProduto = 1, devolverMoedas = 0, valorTroco = 0.
  - `ack` one cycle later: all outputs 0, ocupado = 0.
- Change: credit 10, code 6.
  - liberarProduto = 1, devolverMoedas = 1, valorTroco = 2.
- Insufficient credit and invalid code:
  - Credit 3, code 2 → DEVOLVE, valorTroco = 3, erro = 0.
  - Code 0 or code 7 with credit 4 → DEVOLVE, valorTroco = 4, erro = 1.
- Timeout path: credit 9, code 1, `ack` never asserted.
  - LIBERA (valorTroco = 7) for 16 cycles.
  - Then DEVOLVE with valorTroco = 9 and erro = 1 for 16 cycles.
  - Then OCIOSO with erro still 1.
  - Next request clears erro.
- Edge and busy rules:
  - `enable` held high across reset → no transaction.
  - Second `enable` edge during LIBERA → ignored.
  - `ack` coincident with the timeout cycle → normal completion, erro = 0.
- Reset mid-LIBERA: all outputs 0 on the next edge; no refund issued; the next request behaves normally.
